// File: rtl/rr_arb4_if.sv
// Request/grant bundle between rr_arb4 and its four requesters.
interface rr_arb4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with release on done or dropped request.
// Optional forced release after MAX_HOLD cycles when RR_ARB4_TIMEOUT_EN is defined.
module rr_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input logic     clk,
  input logic     rst_n,
  rr_arb4_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4: MAX_HOLD must be within 2..255");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] win_s;
  logic       release_s;
  logic       force_s;

  // First set request bit at or above ptr, wrapping 3 -> 0.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        w = idx;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  assign win_s     = pick_winner(bus.req, ptr_q);
  assign release_s = bus.done || !bus.req[gnt_id_q];

  // Next-state and grant decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d     = ST_GRANT;
          gnt_d       = 4'b0001 << win_s;
          gnt_id_d    = win_s;
          gnt_valid_d = 1'b1;
          ptr_d       = win_s + 2'd1;
        end else begin
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s || force_s) begin
          state_d     = ST_IDLE;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 4'b0000;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;

`ifdef RR_ARB4_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign force_s = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);

  // Hold counter restarts on every grant; timeout only when nothing else released.
  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == ST_GRANT) begin
      if (release_s || force_s) begin
        hold_d    = 8'd0;
        timeout_d = force_s && !release_s;
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end else begin
      hold_d = 8'd0;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_s     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4.sv
// Directed-vector scoreboard bench for rr_arb4; expectations queued by stimulus, checked by monitor.
module tb_rr_arb4;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  rr_arb4_if bus_if ();

  rr_arb4 #(.MAX_HOLD(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct {
    int          due;
    logic [3:0]  gnt;
    logic        to;
    logic [95:0] name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (bus_if.gnt !== mon_e.gnt || bus_if.gnt_id !== enc(mon_e.gnt) ||
          bus_if.gnt_valid !== (|mon_e.gnt) || bus_if.timeout !== mon_e.to) begin
        bad++;
        $display("FAIL %0s @cyc %0d: got gnt=%b id=%0d v=%b to=%b, want gnt=%b id=%0d v=%b to=%b",
                 mon_e.name, cyc, bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout,
                 mon_e.gnt, enc(mon_e.gnt), |mon_e.gnt, mon_e.to);
      end
    end
  end

  task automatic vec(input logic [3:0] r, input logic d, input logic [3:0] eg,
                     input logic eto, input logic [95:0] nm);
    exp_t e;
    bus_if.req  = r;
    bus_if.done = d;
    e.due  = cyc + 1;
    e.gnt  = eg;
    e.to   = eto;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input logic [95:0] nm);
    total++;
    if (bus_if.gnt !== 4'b0000 || bus_if.gnt_id !== 2'd0 ||
        bus_if.gnt_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
      bad++;
      $display("FAIL %0s: got gnt=%b id=%0d v=%b to=%b, want all zero",
               nm, bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n       = 1'b0;
    bus_if.req  = 4'b0000;
    bus_if.done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus_if.req  = 4'b0000;
    bus_if.done = 1'b0;
    #3;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // req=0101, done on third cycle of each grant
    vec(4'b0101, 1'b0, 4'b0001, 1'b0, "p29_g0_c1");
    vec(4'b0101, 1'b0, 4'b0001, 1'b0, "p29_g0_c2");
    vec(4'b0101, 1'b0, 4'b0001, 1'b0, "p29_g0_c3");
    vec(4'b0101, 1'b1, 4'b0000, 1'b0, "p29_rel0");
    vec(4'b0101, 1'b0, 4'b0100, 1'b0, "p29_g2_c1");
    vec(4'b0101, 1'b0, 4'b0100, 1'b0, "p29_g2_c2");
    vec(4'b0101, 1'b0, 4'b0100, 1'b0, "p29_g2_c3");
    vec(4'b0101, 1'b1, 4'b0000, 1'b0, "p29_rel2");
    vec(4'b0101, 1'b0, 4'b0001, 1'b0, "p29_g0_again");
    vec(4'b0101, 1'b1, 4'b0000, 1'b0, "p29_rel_end");

    // all four requesting: strict rotation with one idle cycle between grants
    do_reset();
    vec(4'b1111, 1'b0, 4'b0001, 1'b0, "rot_g0");
    vec(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_idle0");
    vec(4'b1111, 1'b0, 4'b0010, 1'b0, "rot_g1");
    vec(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_idle1");
    vec(4'b1111, 1'b0, 4'b0100, 1'b0, "rot_g2");
    vec(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_idle2");
    vec(4'b1111, 1'b0, 4'b1000, 1'b0, "rot_g3");
    vec(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_idle3");
    vec(4'b1111, 1'b0, 4'b0001, 1'b0, "rot_wrap0");

    // done in idle, non-owner requests, request drop, simultaneous release
    do_reset();
    vec(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_done");
    vec(4'b0100, 1'b0, 4'b0100, 1'b0, "own2");
    vec(4'b1110, 1'b0, 4'b0100, 1'b0, "ignore_oth");
    vec(4'b1010, 1'b0, 4'b0000, 1'b0, "req_drop");
    vec(4'b1010, 1'b0, 4'b1000, 1'b0, "after_drop");
    vec(4'b0010, 1'b1, 4'b0000, 1'b0, "dual_rel");
    vec(4'b0010, 1'b0, 4'b0010, 1'b0, "wrap_own1");

    // asynchronous reset between edges while owner 1 holds the grant
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.req = 4'b0000;
    @(posedge clk);
    #1;
    vec(4'b1000, 1'b0, 4'b1000, 1'b0, "post_rst_g3");
    vec(4'b0000, 1'b0, 4'b0000, 1'b0, "post_rst_rel");

    // held request with no done
    do_reset();
`ifdef RR_ARB4_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      vec(4'b0010, 1'b0, 4'b0010, 1'b0, "hold_8");
    end
    vec(4'b0010, 1'b0, 4'b0000, 1'b1, "timeout");
    vec(4'b0010, 1'b0, 4'b0010, 1'b0, "regrant1");
    vec(4'b0010, 1'b1, 4'b0000, 1'b0, "regrant_rel");
`else
    for (int i = 0; i < 100; i++) begin
      vec(4'b0010, 1'b0, 4'b0010, 1'b0, "hold_100");
    end
    vec(4'b0010, 1'b1, 4'b0000, 1'b0, "hold_rel");
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per owner (range 2..255); used only when RR_ARB4_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request vector, bit i = requester i.
REQ-005 Port: done  input  1  current owner releases the resource, sampled only in GRANT.
REQ-006 Port: gnt  output  4  one-hot grant, registered, all-zero when no owner.
REQ-007 Port: gnt_id  output  2  encoded index of the current owner, 0 when gnt is all-zero.
REQ-008 Port: gnt_valid  output  1  high while exactly one gnt bit is high.
REQ-009 Port: timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-010 FSM states: IDLE and GRANT.
REQ-011 IDLE to GRANT: when req is nonzero at a clk edge, the winner is registered on that edge; latency is 1 cycle from req sampled to gnt visible.
REQ-012 Winner: first set bit of req searched upward from pointer ptr (2-bit), wrapping 3 to 0.
REQ-013 On every grant to requester k, ptr is set to (k+1) mod 4.
REQ-014 GRANT hold: gnt, gnt_id and ptr are unchanged while req[owner]=1 and done=0.
REQ-015 GRANT to IDLE: on an edge where done=1 or req[owner]=0, outputs clear on that edge.
REQ-016 After a release, IDLE lasts exactly 1 cycle before any new grant, so back-to-back grants are separated by 1 empty cycle.
REQ-017 Requests from non-owners during GRANT are ignored; they are not queued and must stay asserted.
REQ-018 A done pulse in IDLE has no effect.
REQ-019 Simultaneous done=1 and req[owner]=0: single release, no timeout pulse.
REQ-020 Invariants: gnt is one-hot or zero; gnt_valid equals |gnt; gnt_id is consistent with gnt in every cycle.
REQ-021 Fairness: with all 4 requesters continuously active, grants rotate 0,1,2,3,0,... .

Reset
REQ-022 While rst_n=0, asynchronously: state=IDLE, ptr=0, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, hold counter=0.
REQ-023 Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.
REQ-024 First grant after reset deassertion uses ptr=0, so requester 0 has highest priority.

Configuration
REQ-025 Macro RR_ARB4_TIMEOUT_EN defined: an 8-bit hold counter clears on each grant and increments each cycle in GRANT.
REQ-026 Timeout behaviour: when the counter reaches MAX_HOLD-1 with no release, the next edge forces a release (as REQ-015) and pulses timeout for 1 cycle.
REQ-027 Macro RR_ARB4_TIMEOUT_EN undefined: the counter is not instantiated, timeout is tied to 0, and ownership is unbounded.
REQ-028 All other behaviour is identical with and without the macro.

Verification
REQ-029 Reset then req=4'b0101 held, done pulsed 1 cycle at cycle 3 of each grant -> gnt sequence 0001, 0000, 0100, 0000, 0001; gnt_id 0, 2, 0.
REQ-030 req=4'b1111 held, done pulsed on each grant -> gnt_id sequence 0,1,2,3,0 with 1 idle cycle between grants.
REQ-031 Owner 2 granted, then req[2] deasserts with done=0 -> gnt=0000 on the next edge, timeout=0.
REQ-032 rst_n driven low mid-grant between clock edges -> gnt, gnt_valid and gnt_id go to 0 immediately; after release, req=4'b1000 -> gnt_id=3 after 1 cycle.
REQ-033 RR_ARB4_TIMEOUT_EN defined, MAX_HOLD=8, req=4'b0010 held, done=0 -> gnt=0010 for exactly 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then regrant to 1.
REQ-034 RR_ARB4_TIMEOUT_EN undefined, same stimulus as REQ-033 -> gnt=0010 held for 100 cycles, timeout stays 0.
